// File: rtl/fwd_pkg.sv
// Shared types and constants for the pipeline forwarding/hazard controller.
// Scoreboard slots carry a fixed-width destination field; narrower register
// addresses are zero-extended into it, so AW may be at most SB_DEST_W.
package fwd_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam int SB_DEST_W = 8;

    typedef logic [SB_DEST_W-1:0] sb_dest_t;

    localparam sb_dest_t REG_ZERO = '0;

    typedef struct packed {
        logic     valid;
        logic     regwrite;
        logic     memread;
        sb_dest_t dest;
    } sb_slot_t;

    localparam sb_slot_t SLOT_EMPTY = '0;

    // A slot produces register r only if it is a live writer of a non-zero register.
    function automatic logic slot_match(input sb_slot_t s, input sb_dest_t r);
        return s.valid & s.regwrite & (s.dest != REG_ZERO) & (s.dest == r);
    endfunction

endpackage

// File: rtl/pipeline_fwd_ctrl_if.sv
// ID-stage request / EX-stage select bundle for pipeline_fwd_ctrl.
// HAZ_STATS_EN adds the profiling counter outputs.
interface pipeline_fwd_ctrl_if #(
    parameter int AW = 5
);
    logic [AW-1:0] ID_rs;
    logic [AW-1:0] ID_rt;
    logic          ID_UsesRs;
    logic          ID_UsesRt;
    logic          ID_RegWrite;
    logic          ID_MemRead;
    logic [AW-1:0] ID_WriteReg;
    logic          EX_BranchTaken;
    logic          Hold;
    logic [1:0]    ForwardA;
    logic [1:0]    ForwardB;
    logic          Stall;
    logic          Bubble;
    logic          Flush;
`ifdef HAZ_STATS_EN
    logic [31:0]   StallCnt;
    logic [31:0]   FlushCnt;
    logic [31:0]   FwdCnt;
`endif

    modport master (
        output ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead,
               ID_WriteReg, EX_BranchTaken, Hold,
`ifdef HAZ_STATS_EN
        input  StallCnt, FlushCnt, FwdCnt,
`endif
        input  ForwardA, ForwardB, Stall, Bubble, Flush
    );

    modport slave (
        input  ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead,
               ID_WriteReg, EX_BranchTaken, Hold,
`ifdef HAZ_STATS_EN
        output StallCnt, FlushCnt, FwdCnt,
`endif
        output ForwardA, ForwardB, Stall, Bubble, Flush
    );

endinterface

// File: rtl/fwd_sel.sv
// Priority forward select for one EX operand: the youngest producer (EX/MEM)
// wins over MEM/WB; anything older is read from the write-first register file.
module fwd_sel
    import fwd_pkg::*;
(
    input  sb_slot_t   s_ex,
    input  sb_slot_t   s_mem,
    input  sb_dest_t   src,
    input  logic       uses,
    output logic [1:0] code
);

    // Load flags only matter for hazard detection, not operand selection.
    logic unused_memread;
    assign unused_memread = s_ex.memread ^ s_mem.memread;

    // Pick the forward source for this operand.
    always_comb begin
        code = FWD_RF;
        if (uses && slot_match(s_ex, src)) begin
            code = FWD_EXMEM;
        end else if (uses && slot_match(s_mem, src)) begin
            code = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_fwd_ctrl.sv
// Forwarding and hazard controller for a 5-stage pipeline.
// Shadows the EX/MEM/WB destinations, registers ForwardA/ForwardB so they line
// up with the consumer's EX cycle, and raises Stall/Bubble on load-use hazards
// and Flush/Bubble on taken branches. A taken branch suppresses the stall.
// Optional macro HAZ_STATS_EN adds saturating StallCnt/FlushCnt/FwdCnt.
module pipeline_fwd_ctrl
    import fwd_pkg::*;
#(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    pipeline_fwd_ctrl_if.slave  bus
);

    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic [AW-1:0] id_wr;
    sb_dest_t      rs_ext;
    sb_dest_t      rt_ext;
    sb_dest_t      wr_ext;

    assign id_rs  = bus.ID_rs;
    assign id_rt  = bus.ID_rt;
    assign id_wr  = bus.ID_WriteReg;
    assign rs_ext = sb_dest_t'(id_rs);
    assign rt_ext = sb_dest_t'(id_rt);
    assign wr_ext = sb_dest_t'(id_wr);

    sb_slot_t   sb_ex_q, sb_ex_d;
    sb_slot_t   sb_mem_q, sb_mem_d;
    sb_slot_t   sb_wb_q, sb_wb_d;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_a_nx;
    logic [1:0] fwd_b_q, fwd_b_d, fwd_b_nx;
    logic [1:0] sel_a, sel_b;
    logic       lu;
    logic       bubble_raw;
    logic       stall_c, bubble_c, flush_c;
    sb_slot_t   id_slot;

    // WB occupancy is tracked for completeness; the write-first register file
    // means it never needs a forward path.
    logic unused_wb;
    assign unused_wb = ^sb_wb_q;

    fwd_sel u_sel_a (
        .s_ex  (sb_ex_q),
        .s_mem (sb_mem_q),
        .src   (rs_ext),
        .uses  (bus.ID_UsesRs),
        .code  (sel_a)
    );

    fwd_sel u_sel_b (
        .s_ex  (sb_ex_q),
        .s_mem (sb_mem_q),
        .src   (rt_ext),
        .uses  (bus.ID_UsesRt),
        .code  (sel_b)
    );

    // Load-use detection and the branch/stall priority for the control outputs.
    always_comb begin
        lu = (bus.ID_UsesRs && slot_match(sb_ex_q, rs_ext) && sb_ex_q.memread) ||
             (bus.ID_UsesRt && slot_match(sb_ex_q, rt_ext) && sb_ex_q.memread);
        if (LOAD_LAT == 2) begin
            lu = lu ||
                 (bus.ID_UsesRs && slot_match(sb_mem_q, rs_ext) && sb_mem_q.memread) ||
                 (bus.ID_UsesRt && slot_match(sb_mem_q, rt_ext) && sb_mem_q.memread);
        end
        bubble_raw = lu || bus.EX_BranchTaken;
        stall_c    = !reset && lu && !bus.EX_BranchTaken;
        bubble_c   = !reset && bubble_raw;
        flush_c    = !reset && bus.EX_BranchTaken;
    end

    assign bus.Stall  = stall_c;
    assign bus.Bubble = bubble_c;
    assign bus.Flush  = flush_c;

    // Advance the shadow scoreboard and forward codes unless the pipe is held.
    always_comb begin
        id_slot.valid    = 1'b1;
        id_slot.regwrite = bus.ID_RegWrite;
        id_slot.memread  = bus.ID_MemRead;
        id_slot.dest     = wr_ext;

        fwd_a_nx = bubble_raw ? FWD_RF : sel_a;
        fwd_b_nx = bubble_raw ? FWD_RF : sel_b;

        sb_ex_d  = sb_ex_q;
        sb_mem_d = sb_mem_q;
        sb_wb_d  = sb_wb_q;
        fwd_a_d  = fwd_a_q;
        fwd_b_d  = fwd_b_q;
        if (!bus.Hold) begin
            sb_wb_d  = sb_mem_q;
            sb_mem_d = sb_ex_q;
            sb_ex_d  = bubble_raw ? SLOT_EMPTY : id_slot;
            fwd_a_d  = fwd_a_nx;
            fwd_b_d  = fwd_b_nx;
        end
    end

    // Scoreboard and forward-code registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_ex_q  <= SLOT_EMPTY;
            sb_mem_q <= SLOT_EMPTY;
            sb_wb_q  <= SLOT_EMPTY;
            fwd_a_q  <= FWD_RF;
            fwd_b_q  <= FWD_RF;
        end else begin
            sb_ex_q  <= sb_ex_d;
            sb_mem_q <= sb_mem_d;
            sb_wb_q  <= sb_wb_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
        end
    end

    assign bus.ForwardA = fwd_a_q;
    assign bus.ForwardB = fwd_b_q;

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic        fwd_evt;

    // Saturating event counters, advanced only on non-hold edges.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        fwd_evt     = (fwd_a_nx != FWD_RF) || (fwd_b_nx != FWD_RF);
        if (!bus.Hold) begin
            if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
            if (flush_c && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
            if (fwd_evt && (fwd_cnt_q != '1))   fwd_cnt_d   = fwd_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign bus.StallCnt = stall_cnt_q;
    assign bus.FlushCnt = flush_cnt_q;
    assign bus.FwdCnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_fwd_ctrl.sv
// Bench for pipeline_fwd_ctrl: a vector table of instruction streams with
// hand-derived control/forward expectations, plus hand-written sequences for
// mid-cycle reset and the LOAD_LAT = 2 variant.
module tb_pipeline_fwd_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_fwd_ctrl_if #(.AW(5)) bus1 ();
    pipeline_fwd_ctrl_if #(.AW(5)) bus2 ();

    pipeline_fwd_ctrl #(.AW(5), .LOAD_LAT(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    pipeline_fwd_ctrl #(.AW(5), .LOAD_LAT(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    assign bus2.ID_rs          = bus1.ID_rs;
    assign bus2.ID_rt          = bus1.ID_rt;
    assign bus2.ID_UsesRs      = bus1.ID_UsesRs;
    assign bus2.ID_UsesRt      = bus1.ID_UsesRt;
    assign bus2.ID_RegWrite    = bus1.ID_RegWrite;
    assign bus2.ID_MemRead     = bus1.ID_MemRead;
    assign bus2.ID_WriteReg    = bus1.ID_WriteReg;
    assign bus2.EX_BranchTaken = bus1.EX_BranchTaken;
    assign bus2.Hold           = bus1.Hold;

    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt, rw, mr;
        logic [4:0] wr;
        logic       br, hold;
        logic       stall, bubble, flush;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] sb_q[$];
    int         idx_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    function automatic vec_t mk(int rs, int rt, int urs, int urt, int rw, int mr, int wr,
                                int br, int hold, int st, int bu, int fl, int fa, int fb);
        vec_t v;
        v.rs = 5'(rs);   v.rt = 5'(rt);
        v.urs = 1'(urs); v.urt = 1'(urt); v.rw = 1'(rw); v.mr = 1'(mr);
        v.wr = 5'(wr);   v.br = 1'(br);   v.hold = 1'(hold);
        v.stall = 1'(st); v.bubble = 1'(bu); v.flush = 1'(fl);
        v.fa = 2'(fa);   v.fb = 2'(fb);
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input int rs, input int rt, input int urs, input int urt,
                         input int rw, input int mr, input int wr, input int br, input int hold);
        bus1.ID_rs = 5'(rs);           bus1.ID_rt = 5'(rt);
        bus1.ID_UsesRs = 1'(urs);      bus1.ID_UsesRt = 1'(urt);
        bus1.ID_RegWrite = 1'(rw);     bus1.ID_MemRead = 1'(mr);
        bus1.ID_WriteReg = 5'(wr);     bus1.EX_BranchTaken = 1'(br);
        bus1.Hold = 1'(hold);
    endtask

    task automatic apply_row(input int i);
        vec_t       v;
        logic [3:0] e;
        int         k;
        v = tbl[i];
        @(negedge clk);
        drive(v.rs, v.rt, v.urs, v.urt, v.rw, v.mr, v.wr, v.br, v.hold);
        #1;
        check($sformatf("row%0d stall", i),  4'(bus1.Stall),  4'(v.stall));
        check($sformatf("row%0d bubble", i), 4'(bus1.Bubble), 4'(v.bubble));
        check($sformatf("row%0d flush", i),  4'(bus1.Flush),  4'(v.flush));
        sb_q.push_back({v.fa, v.fb});
        idx_q.push_back(i);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        k = idx_q.pop_front();
        check($sformatf("row%0d ForwardA", k), 4'(bus1.ForwardA), 4'(e[3:2]));
        check($sformatf("row%0d ForwardB", k), 4'(bus1.ForwardB), 4'(e[1:0]));
    endtask

    initial begin
        //          rs  rt urs urt rw mr  wr br hd  st bu fl fa fb
        tbl.push_back(mk( 0,  0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // addi $1
        tbl.push_back(mk( 1,  1, 1, 1, 1, 0,  2, 0, 0, 0, 0, 0, 2, 2)); // add $2,$1,$1
        tbl.push_back(mk( 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // nop
        tbl.push_back(mk( 0,  0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // addi $1
        tbl.push_back(mk( 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // nop
        tbl.push_back(mk( 1,  4, 1, 1, 1, 0,  3, 0, 0, 0, 0, 0, 1, 0)); // sub $3,$1,$4
        tbl.push_back(mk( 3,  0, 1, 0, 1, 1,  5, 0, 0, 0, 0, 0, 2, 0)); // lw $5,0($3)
        tbl.push_back(mk( 5,  0, 1, 1, 1, 0,  6, 0, 0, 1, 1, 0, 0, 0)); // add $6,$5,$0 stalls
        tbl.push_back(mk( 5,  0, 1, 1, 1, 0,  6, 0, 0, 0, 0, 0, 1, 0)); // add replayed
        tbl.push_back(mk( 2,  6, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0)); // lw $0, rt unused
        tbl.push_back(mk( 0,  0, 1, 1, 1, 0,  7, 0, 0, 0, 0, 0, 0, 0)); // use $0: no stall
        tbl.push_back(mk( 0,  0, 1, 0, 1, 1,  8, 0, 0, 0, 0, 0, 0, 0)); // lw $8
        tbl.push_back(mk( 1,  8, 1, 1, 1, 0,  9, 1, 0, 0, 1, 1, 0, 0)); // load-use + branch
        tbl.push_back(mk( 8,  7, 1, 1, 1, 0, 10, 0, 0, 0, 0, 0, 1, 0)); // add $10,$8,$7
        tbl.push_back(mk(10, 10, 1, 1, 1, 0, 11, 0, 0, 0, 0, 0, 2, 2)); // sub $11,$10,$10
        tbl.push_back(mk(11, 10, 1, 1, 1, 0, 12, 0, 1, 0, 0, 0, 2, 2)); // hold
        tbl.push_back(mk(11, 10, 1, 1, 1, 0, 12, 0, 1, 0, 0, 0, 2, 2)); // hold
        tbl.push_back(mk(11, 10, 1, 1, 1, 0, 12, 0, 1, 0, 0, 0, 2, 2)); // hold
        tbl.push_back(mk(11, 10, 1, 1, 1, 0, 12, 0, 0, 0, 0, 0, 2, 1)); // released
        tbl.push_back(mk(12,  0, 1, 0, 0, 0,  0, 1, 1, 0, 1, 1, 2, 1)); // branch under hold
        tbl.push_back(mk(12,  0, 1, 0, 0, 0,  0, 1, 0, 0, 1, 1, 0, 0)); // branch takes effect
        tbl.push_back(mk(12,  0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0)); // reads $12 from MEM
        tbl.push_back(mk( 0,  0, 1, 0, 1, 1, 13, 0, 0, 0, 0, 0, 0, 0)); // lw $13
        tbl.push_back(mk( 0, 13, 1, 1, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0)); // sw $13 stalls on rt
        tbl.push_back(mk( 0, 13, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1)); // sw replayed

        // Reset state; a branch request must not leak through while in reset.
        reset = 1'b1;
        drive(3, 3, 1, 1, 1, 1, 3, 1, 0);
        #2;
        check("reset ForwardA", 4'(bus1.ForwardA), 4'd0);
        check("reset ForwardB", 4'(bus1.ForwardB), 4'd0);
        check("reset Flush",    4'(bus1.Flush),    4'd0);
        check("reset Bubble",   4'(bus1.Bubble),   4'd0);
        check("reset Stall",    4'(bus1.Stall),    4'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) apply_row(i);

        // Mid-stream asynchronous reset while a forward and a stall are live.
        @(negedge clk); drive(0, 0, 1, 0, 1, 0, 1, 0, 0);   // addi $1
        @(negedge clk); drive(1, 0, 1, 0, 1, 1, 5, 0, 0);   // lw $5,0($1)
        @(posedge clk); #1;
        check("seq lw ForwardA", 4'(bus1.ForwardA), 4'd2);
        @(negedge clk); drive(5, 5, 1, 1, 1, 0, 6, 0, 0);   // add $6,$5,$5
        #1;
        check("seq lu Stall", 4'(bus1.Stall), 4'd1);
        #2;
        reset = 1'b1;
        bus1.EX_BranchTaken = 1'b1;
        #1;
        check("async rst ForwardA", 4'(bus1.ForwardA), 4'd0);
        check("async rst Stall",    4'(bus1.Stall),    4'd0);
        check("async rst Bubble",   4'(bus1.Bubble),   4'd0);
        check("async rst Flush",    4'(bus1.Flush),    4'd0);
        check("async rst Stall2",   4'(bus2.Stall),    4'd0);

        // lw $5 then add $6,$5,$0 on both LOAD_LAT variants.
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 1, 0, 1, 1, 5, 0, 0);                   // lw $5
        @(negedge clk); drive(5, 0, 1, 1, 1, 0, 6, 0, 0);   // add $6,$5,$0
        #1;
        check("lat1 first Stall", 4'(bus1.Stall), 4'd1);
        check("lat2 first Stall", 4'(bus2.Stall), 4'd1);
        @(negedge clk); #1;
        check("lat1 second Stall", 4'(bus1.Stall),  4'd0);
        check("lat2 second Stall", 4'(bus2.Stall),  4'd1);
        check("lat2 second Bubble", 4'(bus2.Bubble), 4'd1);
        @(posedge clk); #1;
        check("lat1 consumer ForwardA", 4'(bus1.ForwardA), 4'd1);
        @(negedge clk); #1;
        check("lat2 third Stall", 4'(bus2.Stall), 4'd0);
        @(posedge clk); #1;
        check("lat2 consumer ForwardA", 4'(bus2.ForwardA), 4'd0);
        check("lat2 consumer ForwardB", 4'(bus2.ForwardB), 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
